// File: rtl/pace_if.sv
// DTI valid/ready stream: data and valid from the producer, ready from the consumer.
// A transfer happens on a cycle where valid and ready are both high.
interface dti #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);
    modport master   (output valid, output data, input ready);
    modport slave    (input valid, input data, output ready);
endinterface

// File: rtl/pace.sv
// Rate-pacing stage: buffers a bursty DTI stream in a small FIFO and releases
// at most one item per PERIOD-cycle slot, flagging empty and stalled slots.
module pace #(
    parameter int          PERIOD = 4,
    parameter int          DEPTH  = 4,
    parameter int          HOLD   = 1,
    parameter int unsigned INIT   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    dti.consumer                       din,
    dti.producer                       dout,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       underrun,
    output logic                       missed
);
    localparam int W  = $bits(din.data);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [CW-1:0] cnt;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [W-1:0]  last_sent;

    logic full;
    logic empty;
    logic push;
    logic tick;
    logic slot_free;
    logic pop;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign push      = din.valid && !full;
    assign tick      = (cnt == CW'(PERIOD - 1));
    assign slot_free = !out_valid || dout.ready;
    assign pop       = tick && slot_free && !empty;

    assign din.ready  = !full;
    assign dout.valid = out_valid;
    assign dout.data  = out_data;
    assign level      = LW'(wr_ptr - rd_ptr);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= din.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= W'(INIT);
            last_sent <= W'(INIT);
            underrun  <= 1'b0;
            missed    <= 1'b0;
        end else begin
            underrun <= 1'b0;
            missed   <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end

            if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (out_valid && dout.ready) begin
                out_valid <= 1'b0;
            end

            // A slot reload overrides the handshake clear, giving back-to-back output.
            if (tick) begin
                if (slot_free) begin
                    if (!empty) begin
                        out_data  <= mem[rd_ptr[AW-1:0]];
                        last_sent <= mem[rd_ptr[AW-1:0]];
                        out_valid <= 1'b1;
                        rd_ptr    <= rd_ptr + (AW+1)'(1);
                    end else begin
                        underrun <= 1'b1;
                        if (HOLD != 0) begin
                            out_data  <= last_sent;
                            out_valid <= 1'b1;
                        end
                    end
                end else begin
                    missed <= 1'b1;
                end
            end
        end
    end

    logic unused_pop;
    assign unused_pop = pop;
endmodule

// File: tb/tb_pace.sv
// Checks two pace instances (HOLD=1 and HOLD=0) against a queue-based slot model
// under directed scenarios followed by randomized traffic, stalls and resets.
module tb_pace;
    localparam int         PERIOD = 4;
    localparam int         DEPTH  = 4;
    localparam logic [7:0] INIT0  = 8'h5A;
    localparam logic [7:0] INIT1  = 8'hC3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dti #(.W(8)) din0 ();
    dti #(.W(8)) dout0 ();
    dti #(.W(8)) din1 ();
    dti #(.W(8)) dout1 ();

    logic [2:0] level0, level1;
    logic       und0, und1, mis0, mis1;

    pace #(.PERIOD(PERIOD), .DEPTH(DEPTH), .HOLD(1), .INIT(32'(INIT0))) u_hold (
        .clk(clk), .rst(rst), .din(din0), .dout(dout0),
        .level(level0), .underrun(und0), .missed(mis0)
    );

    pace #(.PERIOD(PERIOD), .DEPTH(DEPTH), .HOLD(0), .INIT(32'(INIT1))) u_nohold (
        .clk(clk), .rst(rst), .din(din1), .dout(dout1),
        .level(level1), .underrun(und1), .missed(mis1)
    );

    int total  = 0;
    int bad    = 0;
    int cyc_now = 0;

    // Reference model: per instance, a queue of waiting items plus the item on offer.
    typedef logic [7:0] dq_t[$];
    dq_t        mq [2];
    logic       m_ov [2];
    logic [7:0] m_od [2];
    logic [7:0] m_last [2];
    logic       m_und [2];
    logic       m_mis [2];
    int         m_phase;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc_now);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            m_ov[k]   = 1'b0;
            m_od[k]   = (k == 0) ? INIT0 : INIT1;
            m_last[k] = (k == 0) ? INIT0 : INIT1;
            m_und[k]  = 1'b0;
            m_mis[k]  = 1'b0;
        end
        m_phase = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic rdy);
        bit is_slot;
        bit accept;
        bit slot_open;
        is_slot = ((m_phase % PERIOD) == PERIOD - 1);
        for (int k = 0; k < 2; k++) begin
            accept    = v && (mq[k].size() < DEPTH);
            slot_open = !m_ov[k] || rdy;
            m_und[k]  = 1'b0;
            m_mis[k]  = 1'b0;
            if (m_ov[k] && rdy) m_ov[k] = 1'b0;
            if (is_slot) begin
                if (slot_open) begin
                    if (mq[k].size() > 0) begin
                        m_od[k]   = mq[k].pop_front();
                        m_last[k] = m_od[k];
                        m_ov[k]   = 1'b1;
                    end else begin
                        m_und[k] = 1'b1;
                        if (k == 0) begin
                            m_od[k] = m_last[k];
                            m_ov[k] = 1'b1;
                        end
                    end
                end else begin
                    m_mis[k] = 1'b1;
                end
            end
            if (accept) mq[k].push_back(d);
        end
        m_phase++;
    endtask

    task automatic checkOutput();
        chk("hold.valid",    32'(dout0.valid), 32'(m_ov[0]));
        chk("hold.data",     32'(dout0.data),  32'(m_od[0]));
        chk("hold.ready",    32'(din0.ready),  32'(mq[0].size() < DEPTH));
        chk("hold.level",    32'(level0),      32'(mq[0].size()));
        chk("hold.underrun", 32'(und0),        32'(m_und[0]));
        chk("hold.missed",   32'(mis0),        32'(m_mis[0]));
        chk("nohold.valid",    32'(dout1.valid), 32'(m_ov[1]));
        chk("nohold.data",     32'(dout1.data),  32'(m_od[1]));
        chk("nohold.ready",    32'(din1.ready),  32'(mq[1].size() < DEPTH));
        chk("nohold.level",    32'(level1),      32'(mq[1].size()));
        chk("nohold.underrun", 32'(und1),        32'(m_und[1]));
        chk("nohold.missed",   32'(mis1),        32'(m_mis[1]));
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d, input logic rdy);
        rst         = r;
        din0.valid  = v;
        din0.data   = d;
        din1.valid  = v;
        din1.data   = d;
        dout0.ready = rdy;
        dout1.ready = rdy;
        @(posedge clk);
        if (r) begin
            model_reset();
            cyc_now = 0;
        end else begin
            model_step(v, d, rdy);
            cyc_now++;
        end
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        int pv;
        din0.valid = 1'b0; din0.data = '0;
        din1.valid = 1'b0; din1.data = '0;
        dout0.ready = 1'b1; dout1.ready = 1'b1;
        model_reset();
        @(negedge clk);

        $display("[TB] reset values and first slot with nothing pushed");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        chk("rst.valid",  32'(dout0.valid), 32'd0);
        chk("rst.data0",  32'(dout0.data),  32'(INIT0));
        chk("rst.data1",  32'(dout1.data),  32'(INIT1));
        chk("rst.ready",  32'(din0.ready),  32'd1);
        chk("rst.level",  32'(level0),      32'd0);
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        chk("first.slot.early", 32'(dout0.valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        chk("first.slot.valid",   32'(dout0.valid), 32'd1);
        chk("first.slot.init",    32'(dout0.data),  32'(INIT0));
        chk("first.slot.nohold",  32'(dout1.valid), 32'd0);
        chk("first.slot.underrun", 32'(und0),       32'd1);

        $display("[TB] three items drained at slot rate, then empty slots");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'hA1, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'hB2, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h3C, 1'b1);
        while (cyc_now < 22) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            chk("burst.dinready", 32'(din0.ready), 32'd1);
            if (cyc_now == 4)  chk("slot4.A",  32'(dout0.data), 32'hA1);
            if (cyc_now == 8)  chk("slot8.B",  32'(dout0.data), 32'hB2);
            if (cyc_now == 12) chk("slot12.C", 32'(dout0.data), 32'h3C);
            if (cyc_now == 16 || cyc_now == 20) begin
                chk("hold.repeat.valid", 32'(dout0.valid), 32'd1);
                chk("hold.repeat.data",  32'(dout0.data),  32'h3C);
                chk("hold.underrun",     32'(und0),        32'd1);
                chk("nohold.empty",      32'(dout1.valid), 32'd0);
                chk("nohold.underrun",   32'(und1),        32'd1);
            end
        end

        $display("[TB] backlog with output stalled");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
        while (cyc_now < 16) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        chk("stall.level",  32'(level0),      32'd4);
        chk("stall.full",   32'(din0.ready),  32'd0);
        chk("stall.valid",  32'(dout0.valid), 32'd1);
        chk("stall.data",   32'(dout0.data),  32'h10);
        chk("stall.missed", 32'(mis0),        32'd1);
        repeat (24) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

        $display("[TB] reset in the middle of traffic");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
        chk("pre.level", 32'(level0),      32'd3);
        chk("pre.valid", 32'(dout0.valid), 32'd1);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        chk("mid.level", 32'(level0),      32'd0);
        chk("mid.valid", 32'(dout0.valid), 32'd0);
        chk("mid.data",  32'(dout0.data),  32'(INIT0));
        chk("mid.ready", 32'(din0.ready),  32'd1);
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        chk("post.early", 32'(dout0.valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        chk("post.slot.valid", 32'(dout0.valid), 32'd1);
        chk("post.slot.data",  32'(dout0.data),  32'(INIT0));

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            pv = ((i / 500) % 2 == 0) ? 80 : 20;
            applyStimulus($urandom_range(0, 249) == 0,
                          $urandom_range(0, 99) < pv,
                          8'($urandom),
                          $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pace.md
# pace

Rate-pacing stage that drains a DTI stream at a fixed cadence of at most one item every PERIOD cycles. It buffers bursty upstream traffic in a small FIFO and presents items on a DTI producer port in time-slots. It is the transmit-side counterpart to the sampling stage: it turns an irregular valid/ready stream into a regular, slot-aligned stream that a sampling consumer reads. It also reports slots that could not be filled.

## Interface
Parameters:
- PERIOD, 4: cycles per output slot; must be at least 1.
- DEPTH, 4: FIFO entries; a power of 2, at least 2.
- HOLD, 1: 1 re-emits the last sent value on an empty slot; 0 emits nothing.
- INIT, 0: the dout.data reset value and the first repeat value under HOLD.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- din  dti.consumer  W=$size(din.data)  input stream.
- dout  dti.producer  W  paced output stream.
- level  output  $clog2(DEPTH+1)  current FIFO occupancy.
- underrun  output  1  one-cycle pulse when a slot found the FIFO empty.
- missed  output  1  one-cycle pulse when a slot was skipped because dout is stalled.

## Operation
- FIFO:
  - Circular buffer with wr/rd pointers one bit wider than log2(DEPTH); full and empty are derived from the pointers.
  - din.ready = !full, registered-state based; there is no combinational path from dout.ready.
  - Push on din.valid && din.ready; a pushed item is visible to the slot logic from the next cycle (no bypass).
  - Pointers wrap modulo 2·DEPTH.
- Slot counter cnt:
  - Counts 0..PERIOD-1 and wraps to 0.
  - tick = (cnt == PERIOD-1).
  - With PERIOD=1, tick is asserted every cycle.
- Output register (out_valid, out_data) drives dout.valid and dout.data directly.
  - Cleared on a dout handshake (dout.valid && dout.ready), unless reloaded in the same cycle.
- On tick, with the output register free (out_valid==0, or a handshake in this cycle):
  - FIFO non-empty: pop, load out_data with the popped item, set out_valid, and store the item in the last-sent register.
  - FIFO empty, HOLD=1: load the last-sent value (INIT if nothing has been sent yet), set out_valid, pulse underrun.
  - FIFO empty, HOLD=0: out_valid stays 0 and underrun pulses.
- On tick with the output register occupied and no handshake: no pop, missed pulses, and data and valid are held unchanged.
- A push and a pop in the same cycle leave level unchanged.
- A pop and a handshake in the same cycle reload the register back-to-back with no bubble.
- Reset:
  - Effective in any cycle, including mid-transfer.
  - Clears the pointers, cnt, out_valid, and the last-sent register (set to INIT); FIFO contents are discarded.

## Timing
- Reset values: dout.valid=0, dout.data=INIT, din.ready=1, level=0, underrun=0, missed=0, cnt=0.
- The first tick occurs PERIOD-1 cycles after rst is deasserted. dout.valid rises on the cycle following a tick, so slot edges land at cycles PERIOD, 2·PERIOD, ….
- Latency from a push at cycle t to output: at least 1 cycle to become visible, then the next tick, plus 1 cycle.
- dout obeys DTI: once valid, data and valid stay stable until ready.
- underrun and missed are registered and assert the cycle after the tick that caused them.
- level updates the cycle after a push or pop.

## Test plan
- PERIOD=4, DEPTH=4, dout.ready=1; push A,B,C on cycles 0–2 after reset → dout.valid for one cycle each at cycles 4, 8, 12 carrying A, B, C; din.ready never drops.
- Push 6 items back-to-back with dout.ready=0 → level reaches 4 and din.ready goes low with 4 stored. When ready returns to 1, items exit in order at slot rate and din.ready reasserts the cycle after the first pop.
- HOLD=1: after A, B, C drain, no further pushes → the slots at 16 and 20 carry C with dout.valid=1, and underrun pulses once per slot. With no item ever pushed, the first slot carries INIT.
- HOLD=0, same stimulus → dout.valid stays 0 at cycles 16 and 20, and underrun pulses once per slot.
- Hold dout.ready=0 for 10 cycles with an item in the output register → data and valid stay constant, missed pulses at every tick during the stall, and level does not decrease.
- Assert rst for one cycle while level=3 and dout.valid=1 → the next cycle shows level=0, dout.valid=0, dout.data=INIT; the first new slot appears PERIOD cycles after rst deasserts.
